// File: rtl/mem_arbiter_if.sv
// Handshake bundle around mem_arbiter: IFU and LSU request/response channels plus the shared memory port.
// The master modport is the arbiter's view; slave is the surrounding fetch/lsu/memory side.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                  ifu_req_valid;
  logic                  ifu_req_ready;
  logic [ADDR_W-1:0]     ifu_addr;
  logic                  ifu_rsp_valid;
  logic                  ifu_rsp_ready;
  logic [DATA_W-1:0]     ifu_rdata;

  logic                  lsu_req_valid;
  logic                  lsu_req_ready;
  logic [ADDR_W-1:0]     lsu_addr;
  logic                  lsu_wen;
  logic [DATA_W-1:0]     lsu_wdata;
  logic [DATA_W/8-1:0]   lsu_wmask;
  logic                  lsu_rsp_valid;
  logic                  lsu_rsp_ready;
  logic [DATA_W-1:0]     lsu_rdata;

  logic                  mem_req_valid;
  logic                  mem_req_ready;
  logic [ADDR_W-1:0]     mem_addr;
  logic                  mem_wen;
  logic [DATA_W-1:0]     mem_wdata;
  logic [DATA_W/8-1:0]   mem_wmask;
  logic                  mem_rsp_valid;
  logic                  mem_rsp_ready;
  logic [DATA_W-1:0]     mem_rdata;

  modport master (
    input  ifu_req_valid, ifu_addr, ifu_rsp_ready,
    input  lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask, lsu_rsp_ready,
    input  mem_req_ready, mem_rsp_valid, mem_rdata,
    output ifu_req_ready, ifu_rsp_valid, ifu_rdata,
    output lsu_req_ready, lsu_rsp_valid, lsu_rdata,
    output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask, mem_rsp_ready
  );

  modport slave (
    output ifu_req_valid, ifu_addr, ifu_rsp_ready,
    output lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask, lsu_rsp_ready,
    output mem_req_ready, mem_rsp_valid, mem_rdata,
    input  ifu_req_ready, ifu_rsp_valid, ifu_rdata,
    input  lsu_req_ready, lsu_rsp_valid, lsu_rdata,
    input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask, mem_rsp_ready
  );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one memory port between IFU and LSU, one transaction outstanding at a time.
// Define ARB_RR_EN for round-robin tie breaking; otherwise LSU wins ties (fixed priority).
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  mem_arbiter_if.master bus,
  output logic          busy
);
  localparam int MASK_W = DATA_W / 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  typedef enum logic {
    OWN_IFU = 1'b0,
    OWN_LSU = 1'b1
  } owner_t;

  state_t              state;
  state_t              state_nxt;
  owner_t              owner;
  logic [ADDR_W-1:0]   addr_q;
  logic                wen_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [MASK_W-1:0]   wmask_q;

  logic                tie_to_ifu;
  logic                ifu_win;
  logic                lsu_win;
  logic                accept;
  logic                owner_rsp_ready;

`ifdef ARB_RR_EN
  owner_t              last_grant;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= OWN_LSU;
    end else if (accept) begin
      last_grant <= lsu_win ? OWN_LSU : OWN_IFU;
    end
  end
`endif

  // Winner selection; a lone requester always wins, ties go by the configured policy.
  always_comb begin
`ifdef ARB_RR_EN
    tie_to_ifu = (last_grant == OWN_LSU);
`else
    tie_to_ifu = 1'b0;
`endif
    ifu_win = bus.ifu_req_valid && (!bus.lsu_req_valid || tie_to_ifu);
    lsu_win = bus.lsu_req_valid && !ifu_win;
  end

  assign owner_rsp_ready = (owner == OWN_LSU) ? bus.lsu_rsp_ready : bus.ifu_rsp_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // rst_n gates the request readies so nothing is acknowledged while reset is held.
  always_comb begin
    state_nxt          = state;
    accept             = 1'b0;
    bus.ifu_req_ready  = 1'b0;
    bus.lsu_req_ready  = 1'b0;
    bus.ifu_rsp_valid  = 1'b0;
    bus.lsu_rsp_valid  = 1'b0;
    bus.ifu_rdata      = '0;
    bus.lsu_rdata      = '0;
    bus.mem_req_valid  = 1'b0;
    bus.mem_rsp_ready  = 1'b0;
    case (state)
      S_IDLE: begin
        bus.ifu_req_ready = ifu_win && rst_n;
        bus.lsu_req_ready = lsu_win && rst_n;
        accept            = ifu_win || lsu_win;
        if (accept) state_nxt = S_REQ;
      end
      S_REQ: begin
        bus.mem_req_valid = 1'b1;
        if (bus.mem_req_ready) state_nxt = S_RESP;
      end
      S_RESP: begin
        bus.mem_rsp_ready = owner_rsp_ready;
        bus.ifu_rsp_valid = (owner == OWN_IFU) && bus.mem_rsp_valid;
        bus.lsu_rsp_valid = (owner == OWN_LSU) && bus.mem_rsp_valid;
        bus.ifu_rdata     = bus.mem_rdata;
        bus.lsu_rdata     = bus.mem_rdata;
        if (bus.mem_rsp_valid && owner_rsp_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Request capture; IFU fetches and LSU loads never carry a write mask to memory.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner   <= OWN_IFU;
      addr_q  <= '0;
      wen_q   <= 1'b0;
      wdata_q <= '0;
      wmask_q <= '0;
    end else if (accept) begin
      if (lsu_win) begin
        owner   <= OWN_LSU;
        addr_q  <= bus.lsu_addr;
        wen_q   <= bus.lsu_wen;
        wdata_q <= bus.lsu_wdata;
        wmask_q <= bus.lsu_wen ? bus.lsu_wmask : '0;
      end else begin
        owner   <= OWN_IFU;
        addr_q  <= bus.ifu_addr;
        wen_q   <= 1'b0;
        wdata_q <= '0;
        wmask_q <= '0;
      end
    end
  end

  assign bus.mem_addr  = addr_q;
  assign bus.mem_wen   = wen_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_wmask = wmask_q;
  assign busy          = (state != S_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios followed by randomized traffic, all judged by a
// transaction-level model of the arbitration and ownership rules.
module tb_mem_arbiter;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int MASK_W = DATA_W / 8;
`ifdef ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic busy;

  mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model of the one outstanding transaction: held, issued to memory, owner (1 = LSU).
  bit                m_act;
  bit                m_iss;
  bit                m_own;
  bit                m_last = 1'b1;
  logic [ADDR_W-1:0] m_addr;
  bit                m_wen;
  logic [DATA_W-1:0] m_wdata;
  logic [MASK_W-1:0] m_wmask;
  int                grant_log[$];

  task automatic model_check();
    logic [6:0] ctl;
    logic [6:0] ex;
    int         win;
    bit         own_rdy;
    ctl = {bus.ifu_req_ready, bus.lsu_req_ready, bus.ifu_rsp_valid, bus.lsu_rsp_valid,
           bus.mem_req_valid, bus.mem_rsp_ready, busy};
    ex  = '0;
    if (!rst_n) begin
      check("rst_ctl", 64'(ctl), 64'h0);
      check("rst_mem_addr", 64'(bus.mem_addr), 64'h0);
      check("rst_mem_wdata", 64'(bus.mem_wdata), 64'h0);
      check("rst_mem_wen_mask", 64'({bus.mem_wen, bus.mem_wmask}), 64'h0);
      check("rst_rdata", 64'({bus.ifu_rdata, bus.lsu_rdata}), 64'h0);
      m_act  = 1'b0;
      m_iss  = 1'b0;
      m_last = 1'b1;
      return;
    end
    if (!m_act) begin
      win = -1;
      if (bus.ifu_req_valid && bus.lsu_req_valid) win = RR ? (m_last ? 0 : 1) : 1;
      else if (bus.ifu_req_valid) win = 0;
      else if (bus.lsu_req_valid) win = 1;
      ex[6] = (win == 0);
      ex[5] = (win == 1);
      check("idle_ctl", 64'(ctl), 64'(ex));
      if (win >= 0) begin
        m_act = 1'b1;
        m_iss = 1'b0;
        m_own = (win == 1);
        if (RR) m_last = (win == 1);
        if (win == 1) begin
          m_addr  = bus.lsu_addr;
          m_wen   = bus.lsu_wen;
          m_wdata = bus.lsu_wdata;
          m_wmask = bus.lsu_wen ? bus.lsu_wmask : '0;
        end else begin
          m_addr  = bus.ifu_addr;
          m_wen   = 1'b0;
          m_wdata = '0;
          m_wmask = '0;
        end
      end
    end else if (!m_iss) begin
      ex[2] = 1'b1;
      ex[0] = 1'b1;
      check("req_ctl", 64'(ctl), 64'(ex));
      check("req_addr", 64'(bus.mem_addr), 64'(m_addr));
      check("req_wen", 64'(bus.mem_wen), 64'(m_wen));
      check("req_wmask", 64'(bus.mem_wmask), 64'(m_wmask));
      if (m_wen) check("req_wdata", 64'(bus.mem_wdata), 64'(m_wdata));
      if (bus.mem_req_ready) m_iss = 1'b1;
    end else begin
      own_rdy = m_own ? bus.lsu_rsp_ready : bus.ifu_rsp_ready;
      ex[4] = !m_own && bus.mem_rsp_valid;
      ex[3] = m_own && bus.mem_rsp_valid;
      ex[1] = own_rdy;
      ex[0] = 1'b1;
      check("rsp_ctl", 64'(ctl), 64'(ex));
      check("rsp_ifu_rdata", 64'(bus.ifu_rdata), 64'(bus.mem_rdata));
      check("rsp_lsu_rdata", 64'(bus.lsu_rdata), 64'(bus.mem_rdata));
      if (bus.mem_rsp_valid && own_rdy) begin
        m_act = 1'b0;
        m_iss = 1'b0;
      end
    end
    if (bus.ifu_req_ready) grant_log.push_back(0);
    if (bus.lsu_req_ready) grant_log.push_back(1);
  endtask

  task automatic settle();
    #2;
    model_check();
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    settle();
    adv();
  endtask

  task automatic idle_inputs();
    bus.ifu_req_valid = 1'b0;
    bus.ifu_addr      = '0;
    bus.ifu_rsp_ready = 1'b0;
    bus.lsu_req_valid = 1'b0;
    bus.lsu_addr      = '0;
    bus.lsu_wen       = 1'b0;
    bus.lsu_wdata     = '0;
    bus.lsu_wmask     = '0;
    bus.lsu_rsp_ready = 1'b0;
    bus.mem_req_ready = 1'b0;
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rdata     = '0;
  endtask

  task automatic random_inputs();
    bus.ifu_req_valid = 1'($urandom);
    bus.ifu_addr      = $urandom;
    bus.ifu_rsp_ready = 1'($urandom);
    bus.lsu_req_valid = 1'($urandom);
    bus.lsu_addr      = $urandom;
    bus.lsu_wen       = 1'($urandom);
    bus.lsu_wdata     = $urandom;
    bus.lsu_wmask     = MASK_W'($urandom);
    bus.lsu_rsp_ready = 1'($urandom);
    bus.mem_req_ready = 1'($urandom);
    bus.mem_rsp_valid = 1'($urandom);
    bus.mem_rdata     = $urandom;
  endtask

  task automatic drain();
    int n;
    n = 0;
    bus.ifu_req_valid = 1'b0;
    bus.lsu_req_valid = 1'b0;
    bus.mem_req_ready = 1'b1;
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rdata     = $urandom;
    bus.ifu_rsp_ready = 1'b1;
    bus.lsu_rsp_ready = 1'b1;
    while (m_act && n < 20) begin
      step();
      n++;
    end
    check("drain_idle", 64'(busy), 64'h0);
  endtask

  function automatic logic [DATA_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h1234_5678;
  endfunction

  task automatic run_random(input int cycles);
    bit                ifu_take;
    bit                lsu_take;
    bit                rsp_on;
    int                rsp_cnt;
    logic [ADDR_W-1:0] rsp_addr;
    ifu_take = 1'b0;
    lsu_take = 1'b0;
    rsp_on   = 1'b0;
    rsp_cnt  = 0;
    rsp_addr = '0;
    for (int c = 0; c < cycles; c++) begin
      if (!bus.ifu_req_valid || ifu_take) begin
        bus.ifu_req_valid = ($urandom % 3) == 0;
        bus.ifu_addr      = 32'h8000_0000 | ($urandom & 32'h0000_FFFC);
      end
      if (!bus.lsu_req_valid || lsu_take) begin
        bus.lsu_req_valid = ($urandom % 3) == 0;
        bus.lsu_addr      = 32'h8001_0000 | ($urandom & 32'h0000_FFFC);
        bus.lsu_wen       = 1'($urandom);
        bus.lsu_wdata     = $urandom;
        bus.lsu_wmask     = MASK_W'($urandom);
      end
      bus.ifu_rsp_ready = ($urandom % 4) != 0;
      bus.lsu_rsp_ready = ($urandom % 4) != 0;
      bus.mem_req_ready = 1'($urandom);
      if (rsp_on) begin
        if (rsp_cnt > 0) begin
          rsp_cnt--;
          bus.mem_rsp_valid = 1'b0;
        end else begin
          bus.mem_rsp_valid = 1'b1;
          bus.mem_rdata     = mem_word(rsp_addr);
        end
      end else begin
        bus.mem_rsp_valid = ($urandom % 4) == 0;
        bus.mem_rdata     = $urandom;
      end
      settle();
      ifu_take = bus.ifu_req_valid && bus.ifu_req_ready;
      lsu_take = bus.lsu_req_valid && bus.lsu_req_ready;
      if (bus.mem_req_valid && bus.mem_req_ready) begin
        rsp_on   = 1'b1;
        rsp_cnt  = $urandom % 4;
        rsp_addr = bus.mem_addr;
      end
      if (bus.mem_rsp_valid && bus.mem_rsp_ready) rsp_on = 1'b0;
      adv();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_grant[4];
    idle_inputs();
    adv();

    // Reset held while inputs toggle.
    for (int i = 0; i < 6; i++) begin
      random_inputs();
      step();
    end
    idle_inputs();
    rst_n = 1'b1;
    step();

    // IFU fetch with two memory stall cycles.
    bus.ifu_req_valid = 1'b1;
    bus.ifu_addr      = 32'h8000_0000;
    step();
    bus.ifu_req_valid = 1'b0;
    bus.ifu_addr      = 32'h0;
    step();
    step();
    bus.mem_req_ready = 1'b1;
    settle();
    check("ifu_mem_addr", 64'(bus.mem_addr), 64'h8000_0000);
    check("ifu_mem_wmask", 64'(bus.mem_wmask), 64'h0);
    adv();
    bus.mem_req_ready = 1'b0;
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rdata     = 32'h0000_0413;
    bus.ifu_rsp_ready = 1'b1;
    bus.lsu_rsp_ready = 1'b1;
    settle();
    check("ifu_rsp_valid", 64'(bus.ifu_rsp_valid), 64'h1);
    check("ifu_rdata", 64'(bus.ifu_rdata), 64'h0000_0413);
    check("ifu_lsu_quiet", 64'(bus.lsu_rsp_valid), 64'h0);
    adv();
    bus.mem_rsp_valid = 1'b0;
    step();

    // LSU store held through three stall cycles.
    idle_inputs();
    bus.lsu_req_valid = 1'b1;
    bus.lsu_addr      = 32'h8000_1000;
    bus.lsu_wen       = 1'b1;
    bus.lsu_wdata     = 32'hDEAD_BEEF;
    bus.lsu_wmask     = 4'hF;
    step();
    bus.lsu_req_valid = 1'b0;
    bus.lsu_addr      = 32'h0;
    bus.lsu_wdata     = 32'h0;
    bus.lsu_wmask     = 4'h0;
    for (int i = 0; i < 3; i++) begin
      settle();
      check("st_addr", 64'(bus.mem_addr), 64'h8000_1000);
      check("st_wdata", 64'(bus.mem_wdata), 64'hDEAD_BEEF);
      check("st_wen_mask", 64'({bus.mem_wen, bus.mem_wmask}), 64'h1F);
      adv();
    end
    bus.mem_req_ready = 1'b1;
    step();
    bus.mem_req_ready = 1'b0;
    bus.mem_rsp_valid = 1'b1;
    bus.lsu_rsp_ready = 1'b1;
    settle();
    check("st_ack", 64'(bus.lsu_rsp_valid), 64'h1);
    adv();
    bus.mem_rsp_valid = 1'b0;
    step();

    // Simultaneous requests for four rounds, then LSU withdraws and IFU must be served.
    idle_inputs();
    grant_log.delete();
    bus.ifu_req_valid = 1'b1;
    bus.ifu_addr      = 32'h8000_0100;
    bus.lsu_req_valid = 1'b1;
    bus.lsu_addr      = 32'h8000_2000;
    bus.mem_req_ready = 1'b1;
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rdata     = 32'h1111_2222;
    bus.ifu_rsp_ready = 1'b1;
    bus.lsu_rsp_ready = 1'b1;
    for (int n = 0; n < 40 && grant_log.size() < 4; n++) step();
    bus.lsu_req_valid = 1'b0;
    for (int n = 0; n < 40 && grant_log.size() < 5; n++) step();
    bus.ifu_req_valid = 1'b0;
    check("tie_grants", 64'(grant_log.size()), 64'd5);
    exp_grant = RR ? '{0, 1, 0, 1} : '{1, 1, 1, 1};
    for (int i = 0; i < 4 && i < grant_log.size(); i++)
      check($sformatf("tie_grant%0d", i), 64'(grant_log[i]), 64'(exp_grant[i]));
    if (grant_log.size() > 4) check("tie_then_ifu", 64'(grant_log[4]), 64'd0);
    drain();

    // Owner stalls its response for five cycles while IFU waits.
    idle_inputs();
    bus.lsu_req_valid = 1'b1;
    bus.lsu_addr      = 32'h8000_3000;
    bus.mem_req_ready = 1'b1;
    step();
    bus.lsu_req_valid = 1'b0;
    step();
    bus.mem_req_ready = 1'b0;
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rdata     = 32'hCAFE_0001;
    bus.ifu_req_valid = 1'b1;
    bus.ifu_addr      = 32'h8000_0004;
    bus.ifu_rsp_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      settle();
      check("stall_mem_rsp_ready", 64'(bus.mem_rsp_ready), 64'h0);
      check("stall_busy", 64'(busy), 64'h1);
      check("stall_no_accept", 64'(bus.ifu_req_ready), 64'h0);
      adv();
    end
    bus.lsu_rsp_ready = 1'b1;
    settle();
    check("stall_release", 64'({bus.lsu_rsp_valid, bus.lsu_rdata}), 64'h1_CAFE_0001);
    adv();
    bus.mem_rsp_valid = 1'b0;
    settle();
    check("stall_next_accept", 64'(bus.ifu_req_ready), 64'h1);
    adv();
    bus.ifu_req_valid = 1'b0;
    drain();

    // Reset asserted while the request phase is stalled.
    idle_inputs();
    bus.ifu_req_valid = 1'b1;
    bus.ifu_addr      = 32'h8000_0008;
    step();
    bus.ifu_req_valid = 1'b0;
    step();
    rst_n = 1'b0;
    settle();
    check("rst_in_req", 64'({bus.mem_req_valid, busy}), 64'h0);
    adv();
    rst_n = 1'b1;
    bus.ifu_req_valid = 1'b1;
    bus.ifu_addr      = 32'h8000_000C;
    step();
    bus.ifu_req_valid = 1'b0;
    drain();

    // Randomized traffic.
    idle_inputs();
    run_random(3000);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
